object_depth_mux: RTL
=====================

# object_depth_mux

Parametrised depth-sorted priority mux for sprite objects, sitting between the per-object drawing units and the top-level video mux. It selects which of N_OBJ requesting objects owns the current pixel, with priority set by vertical coordinate: larger Y is drawn in front. It replaces a per-cycle combinational sort with a sequential sort engine that runs once per frame. New order is committed atomically, so priority never changes mid-frame.

## Interface
- N_OBJ, 8: number of object channels (2..32).
- COORD_W, 11: signed coordinate width.
- RGB_W, 8: pixel colour width.
- BG_RGB, 8'hFF: colour output when no object requests (width RGB_W).
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse; snapshot coordinates and start a sort.
- objCoordinates  in  N_OBJ×2×COORD_W signed  per object {[0]=X, [1]=Y}; only Y is used.
- objBusRequest  in  N_OBJ  per-object draw request for the current pixel.
- objBusRGB  in  N_OBJ×RGB_W  per-object colour for the current pixel.
- drawingRequest  out  1  registered; some object owns the pixel.
- objRGB  out  RGB_W  registered winning colour, or BG_RGB.
- sortBusy  out  1  high while the sort engine runs.

## Operation
- Order register `order[k]`, k=0..N_OBJ-1, holds object indices; k=0 is highest priority. Reset value: the identity order (order[k]=k).
- FSM states: IDLE, SORT, COMMIT. Reset state: IDLE.
  - IDLE: on startOfFrame, latch keys (Y of every object) and the index vector (identity), clear the pass counter, and go to SORT.
  - SORT: odd-even transposition sort, one phase per cycle.
    - Even phase compares pairs (0,1),(2,3)… and odd phase compares (1,2),(3,4)…
    - Swap key and index when key[k] < key[k+1] (signed compare).
    - On equal keys, do not swap, so the lower object index keeps priority (stable).
    - After N_OBJ phases, go to COMMIT.
  - COMMIT: copy the sorted indices into `order` in one cycle, then go to IDLE.
- startOfFrame while in SORT or COMMIT restarts: re-latch keys, clear the pass counter, and stay in or return to SORT. No commit happens for the aborted sort.
- Coordinate changes after the snapshot do not affect a sort in progress.
- Pixel path, evaluated every cycle using the current committed `order`:
  - The winner is the smallest k for which objBusRequest[order[k]] is set.
  - objRGB ← objBusRGB[winner]; drawingRequest ← 1.
  - If no object requests: objRGB ← BG_RGB; drawingRequest ← 0.
- Out-of-range or unused indices never occur; the order is always a permutation of 0..N_OBJ-1.

## Timing
- Pixel path: one-cycle latency. Inputs at edge t appear on objRGB/drawingRequest after edge t+1. Both outputs are aligned.
- Reset values: objRGB = 0, drawingRequest = 0, sortBusy = 0, order = identity.
- Sort latency: startOfFrame at edge t → sortBusy high from t+1 for N_OBJ+1 cycles (N_OBJ SORT cycles plus COMMIT). The new order is used by the pixel path from the cycle after COMMIT.
- An asynchronous reset mid-sort discards the sort and returns to identity order immediately.
- startOfFrame and COMMIT in the same cycle: the restart wins and `order` is not updated.

## Configuration
- OBJ_DEPTH_MUX_TRANSP_EN defined: a channel whose objBusRGB equals BG_RGB is treated as not requesting, so a lower-priority object shows through transparent pixels. drawingRequest is then 0 only if every requesting channel is transparent.
- Not defined: objBusRequest alone decides ownership, and BG_RGB pixels from a requesting object are output as-is.

## Test plan
- Reset, then all requests at 0 → objRGB = 0 during reset; after the first clock, objRGB = 8'hFF and drawingRequest = 0. order is the identity.
- N_OBJ=8, Y = {10,50,30,70,20,60,40,0} for objects 0..7, startOfFrame pulse → sortBusy high for 9 cycles. The committed order must be 3,5,1,6,2,4,0,7.
- After that sort, request objects 1 and 3 with RGB 8'h11 and 8'h33 → objRGB = 8'h33 one cycle later. Drop the request from object 3 → objRGB = 8'h11.
- All Y = 100, requests on objects 2 and 6 → object 2 wins (stable tie-break).
- Second startOfFrame 4 cycles into a sort, with new Y values → no intermediate commit. The order reflects only the second snapshot, 9 cycles after the second pulse.
- With the macro defined: object 3 requests with RGB 8'hFF and object 1 requests with 8'h11 → objRGB = 8'h11. Without the macro → objRGB = 8'hFF with drawingRequest = 1.

Source files
------------

// File: rtl/object_depth_mux.sv
// Depth-sorted priority mux for sprite objects: larger Y is drawn in front, with the order re-sorted once per frame.
// Optional: define OBJ_DEPTH_MUX_TRANSP_EN so that pixels equal to BG_RGB are treated as transparent.
module object_depth_mux #(
    parameter int               N_OBJ   = 8,
    parameter int               COORD_W = 11,
    parameter int               RGB_W   = 8,
    parameter logic [RGB_W-1:0] BG_RGB  = 8'hFF
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [N_OBJ*2*COORD_W-1:0] objCoordinates,
    input  logic [N_OBJ-1:0]           objBusRequest,
    input  logic [N_OBJ*RGB_W-1:0]     objBusRGB,
    output logic                       drawingRequest,
    output logic [RGB_W-1:0]           objRGB,
    output logic                       sortBusy
);

    localparam int IDX_W = $clog2(N_OBJ);
    localparam int CNT_W = $clog2(N_OBJ);

    typedef enum logic [1:0] {S_IDLE, S_SORT, S_COMMIT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          pass_q, pass_d;
    logic signed [COORD_W-1:0] key_q  [N_OBJ];
    logic signed [COORD_W-1:0] key_d  [N_OBJ];
    logic signed [COORD_W-1:0] key_step [N_OBJ];
    logic signed [COORD_W-1:0] y_snap [N_OBJ];
    logic [IDX_W-1:0]          idx_q  [N_OBJ];
    logic [IDX_W-1:0]          idx_d  [N_OBJ];
    logic [IDX_W-1:0]          idx_step [N_OBJ];
    logic [IDX_W-1:0]          order_q [N_OBJ];
    logic [IDX_W-1:0]          order_d [N_OBJ];
    logic [RGB_W-1:0]          rgb_arr [N_OBJ];
    logic [N_OBJ-1:0]          eff_req;
    logic [N_OBJ*COORD_W-1:0]  x_all;
    logic                      unused_x;
    logic                      hit;
    logic [RGB_W-1:0]          win_rgb;

    // Only Y takes part in the sort; X is folded away on purpose.
    always_comb begin
        x_all = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            y_snap[i]                  = $signed(objCoordinates[(2*i+1)*COORD_W +: COORD_W]);
            x_all[i*COORD_W +: COORD_W] = objCoordinates[2*i*COORD_W +: COORD_W];
            rgb_arr[i]                 = objBusRGB[i*RGB_W +: RGB_W];
`ifdef OBJ_DEPTH_MUX_TRANSP_EN
            eff_req[i] = objBusRequest[i] && (rgb_arr[i] != BG_RGB);
`else
            eff_req[i] = objBusRequest[i];
`endif
        end
    end
    assign unused_x = ^x_all;

    // One odd-even transposition phase; the strict compare keeps equal keys in index order.
    always_comb begin
        key_step = key_q;
        idx_step = idx_q;
        for (int k = 0; k < N_OBJ - 1; k++) begin
            if ((k % 2) == (pass_q[0] ? 1 : 0) && key_q[k] < key_q[k+1]) begin
                key_step[k]   = key_q[k+1];
                key_step[k+1] = key_q[k];
                idx_step[k]   = idx_q[k+1];
                idx_step[k+1] = idx_q[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        key_d   = key_q;
        idx_d   = idx_q;
        order_d = order_q;
        if (startOfFrame) begin
            key_d   = y_snap;
            for (int i = 0; i < N_OBJ; i++) idx_d[i] = IDX_W'(i);
            pass_d  = '0;
            state_d = S_SORT;
        end else begin
            case (state_q)
                S_SORT: begin
                    key_d  = key_step;
                    idx_d  = idx_step;
                    pass_d = pass_q + 1'b1;
                    if (pass_q == CNT_W'(N_OBJ - 1)) state_d = S_COMMIT;
                end
                S_COMMIT: begin
                    order_d = idx_q;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Scanning from lowest priority upward leaves the highest-priority requester in hit/win_rgb.
    always_comb begin
        hit     = 1'b0;
        win_rgb = BG_RGB;
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            if (eff_req[order_q[k]]) begin
                hit     = 1'b1;
                win_rgb = rgb_arr[order_q[k]];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the sort arrays are small flop arrays, not RAM, so resetting them is cheap and keeps order a valid permutation.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= S_IDLE;
            pass_q         <= '0;
            drawingRequest <= 1'b0;
            objRGB         <= '0;
            for (int i = 0; i < N_OBJ; i++) begin
                key_q[i]   <= '0;
                idx_q[i]   <= IDX_W'(i);
                order_q[i] <= IDX_W'(i);
            end
        end else begin
            state_q        <= state_d;
            pass_q         <= pass_d;
            key_q          <= key_d;
            idx_q          <= idx_d;
            order_q        <= order_d;
            drawingRequest <= hit;
            objRGB         <= win_rgb;
        end
    end

    assign sortBusy = (state_q != S_IDLE);

endmodule
